// File: rtl/object_bbox_pkg.sv
// rtl/object_bbox_pkg.sv - shared video constants and bbox FSM encoding
package object_bbox_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ACTIVE   = 2'd1,
    REPORT   = 2'd2
  } bbox_state_e;

endpackage

// File: rtl/object_bbox_if.sv
// rtl/object_bbox_if.sv - pixel stream in, bounding-box results out
interface object_bbox_if #(
  parameter int INPUT_WIDTH = 10,
  parameter int COORD_WIDTH = 10,
  parameter int COUNT_WIDTH = 19
);
  logic                   frame_start;
  logic                   is_not_blank;
  logic [INPUT_WIDTH-1:0] delta_frame;
  logic [COUNT_WIDTH-1:0] min_pixels;
  logic [COORD_WIDTH-1:0] x_min;
  logic [COORD_WIDTH-1:0] x_max;
  logic [COORD_WIDTH-1:0] y_min;
  logic [COORD_WIDTH-1:0] y_max;
  logic [COUNT_WIDTH-1:0] pixel_count;
  logic                   bbox_found;
  logic                   bbox_valid;

  modport master (
    output frame_start, is_not_blank, delta_frame, min_pixels,
    input  x_min, x_max, y_min, y_max, pixel_count, bbox_found, bbox_valid
  );

  modport slave (
    input  frame_start, is_not_blank, delta_frame, min_pixels,
    output x_min, x_max, y_min, y_max, pixel_count, bbox_found, bbox_valid
  );
endinterface

// File: rtl/object_bbox_raster_counter.sv
// rtl/object_bbox_raster_counter.sv - active-pixel raster position with end-of-frame flag
module raster_counter #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int COORD_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic                   clear_i,
  input  logic                   advance_i,
  output logic [COORD_WIDTH-1:0] x_o,
  output logic [COORD_WIDTH-1:0] y_o,
  output logic                   last_o
);
  localparam logic [COORD_WIDTH-1:0] X_LAST = COORD_WIDTH'(H_ACTIVE - 1);
  localparam logic [COORD_WIDTH-1:0] Y_LAST = COORD_WIDTH'(V_ACTIVE - 1);

  logic [COORD_WIDTH-1:0] x_q, x_d;
  logic [COORD_WIDTH-1:0] y_q, y_d;
  logic                   x_wrap;

  assign x_wrap = (x_q == X_LAST);

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear_i) begin
      x_d = '0;
      y_d = '0;
    end else if (advance_i) begin
      if (x_wrap) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = x_wrap && (y_q == Y_LAST);

endmodule

// File: rtl/object_bbox.sv
// rtl/object_bbox.sv - per-frame bounding box and set-pixel count of a motion mask
module object_bbox
  import object_bbox_pkg::*;
#(
  parameter int INPUT_WIDTH = 10,
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int COORD_WIDTH = 10,
  parameter int COUNT_WIDTH = 19
) (
  input logic          clk,
  input logic          areset,
  object_bbox_if.slave bus
);
  localparam logic [COORD_WIDTH-1:0] X_LAST  = COORD_WIDTH'(H_ACTIVE - 1);
  localparam logic [COORD_WIDTH-1:0] Y_LAST  = COORD_WIDTH'(V_ACTIVE - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  bbox_state_e            state_q, state_d;
  logic [COORD_WIDTH-1:0] x_cnt, y_cnt;
  logic                   eof;
  logic                   pix_valid, pix_set;
  logic                   unused_delta;

  logic [COORD_WIDTH-1:0] x_lo_q, x_lo_d, x_hi_q, x_hi_d;
  logic [COORD_WIDTH-1:0] y_lo_q, y_lo_d, y_hi_q, y_hi_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [COORD_WIDTH-1:0] x_min_q, x_min_d, x_max_q, x_max_d;
  logic [COORD_WIDTH-1:0] y_min_q, y_min_d, y_max_q, y_max_d;
  logic [COUNT_WIDTH-1:0] pcount_q, pcount_d;
  logic                   found_q, found_d;
  logic                   valid_q, valid_d;

  // frame_start wins over a pixel in the same cycle; the mask is saturated so only the MSB matters
  assign pix_valid    = (state_q == ACTIVE) && bus.is_not_blank && !bus.frame_start;
  assign pix_set      = pix_valid && bus.delta_frame[INPUT_WIDTH-1];
  assign unused_delta = ^bus.delta_frame[INPUT_WIDTH-2:0];

  raster_counter #(
    .H_ACTIVE   (H_ACTIVE),
    .V_ACTIVE   (V_ACTIVE),
    .COORD_WIDTH(COORD_WIDTH)
  ) u_raster (
    .clk      (clk),
    .areset   (areset),
    .clear_i  (bus.frame_start),
    .advance_i(pix_valid),
    .x_o      (x_cnt),
    .y_o      (y_cnt),
    .last_o   (eof)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_SOF: if (bus.frame_start) state_d = ACTIVE;
      ACTIVE: begin
        if (bus.frame_start)      state_d = ACTIVE;
        else if (pix_valid && eof) state_d = REPORT;
      end
      REPORT:   state_d = bus.frame_start ? ACTIVE : WAIT_SOF;
      default:  state_d = WAIT_SOF;
    endcase
  end

  always_comb begin
    x_lo_d = x_lo_q;
    x_hi_d = x_hi_q;
    y_lo_d = y_lo_q;
    y_hi_d = y_hi_q;
    cnt_d  = cnt_q;
    if (bus.frame_start) begin
      x_lo_d = X_LAST;
      x_hi_d = '0;
      y_lo_d = Y_LAST;
      y_hi_d = '0;
      cnt_d  = '0;
    end else if (pix_set) begin
      if (x_cnt < x_lo_q) x_lo_d = x_cnt;
      if (x_cnt > x_hi_q) x_hi_d = x_cnt;
      if (y_cnt < y_lo_q) y_lo_d = y_cnt;
      if (y_cnt > y_hi_q) y_hi_d = y_cnt;
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end
  end

  // Results are captured on the REPORT edge, so the last pixel is already in the accumulators
  always_comb begin
    x_min_d  = x_min_q;
    x_max_d  = x_max_q;
    y_min_d  = y_min_q;
    y_max_d  = y_max_q;
    pcount_d = pcount_q;
    found_d  = found_q;
    valid_d  = 1'b0;
    if (state_q == REPORT) begin
      valid_d  = 1'b1;
      pcount_d = cnt_q;
      found_d  = (cnt_q != '0) && (cnt_q >= bus.min_pixels);
      if (cnt_q == '0) begin
        x_min_d = '0;
        x_max_d = '0;
        y_min_d = '0;
        y_max_d = '0;
      end else begin
        x_min_d = x_lo_q;
        x_max_d = x_hi_q;
        y_min_d = y_lo_q;
        y_max_d = y_hi_q;
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q  <= WAIT_SOF;
      x_lo_q   <= '0;
      x_hi_q   <= '0;
      y_lo_q   <= '0;
      y_hi_q   <= '0;
      cnt_q    <= '0;
      x_min_q  <= '0;
      x_max_q  <= '0;
      y_min_q  <= '0;
      y_max_q  <= '0;
      pcount_q <= '0;
      found_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_lo_q   <= x_lo_d;
      x_hi_q   <= x_hi_d;
      y_lo_q   <= y_lo_d;
      y_hi_q   <= y_hi_d;
      cnt_q    <= cnt_d;
      x_min_q  <= x_min_d;
      x_max_q  <= x_max_d;
      y_min_q  <= y_min_d;
      y_max_q  <= y_max_d;
      pcount_q <= pcount_d;
      found_q  <= found_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.x_min       = x_min_q;
  assign bus.x_max       = x_max_q;
  assign bus.y_min       = y_min_q;
  assign bus.y_max       = y_max_q;
  assign bus.pixel_count = pcount_q;
  assign bus.bbox_found  = found_q;
  assign bus.bbox_valid  = valid_q;

endmodule

// File: tb/tb_object_bbox.sv
// tb/tb_object_bbox.sv - scoreboard bench for object_bbox on a reduced raster
module tb_object_bbox;
  localparam int H  = 128;
  localparam int V  = 56;
  localparam int IW = 10;
  localparam int CW = 10;
  localparam int NW = 19;

  typedef struct {
    int xmin, xmax, ymin, ymax, cnt;
    bit found;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic areset;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  bit   mask [0:V-1][0:H-1];
  exp_t sb[$];
  exp_t last_e;

  object_bbox_if #(.INPUT_WIDTH(IW), .COORD_WIDTH(CW), .COUNT_WIDTH(NW)) bus ();

  object_bbox #(
    .INPUT_WIDTH(IW), .H_ACTIVE(H), .V_ACTIVE(V), .COORD_WIDTH(CW), .COUNT_WIDTH(NW)
  ) dut (
    .clk   (clk),
    .areset(areset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mask();
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) mask[y][x] = 1'b0;
  endtask

  task automatic push_expected(input int min_px, input int vcyc);
    exp_t e;
    e.xmin = H - 1; e.xmax = 0; e.ymin = V - 1; e.ymax = 0; e.cnt = 0;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        if (mask[y][x]) begin
          e.cnt++;
          if (x < e.xmin) e.xmin = x;
          if (x > e.xmax) e.xmax = x;
          if (y < e.ymin) e.ymin = y;
          if (y > e.ymax) e.ymax = y;
        end
    if (e.cnt == 0) begin
      e.xmin = 0; e.xmax = 0; e.ymin = 0; e.ymax = 0;
    end
    e.found = (e.cnt > 0) && (e.cnt >= min_px);
    e.cyc   = vcyc;
    sb.push_back(e);
  endtask

  task automatic idle();
    bus.frame_start  = 1'b0;
    bus.is_not_blank = 1'b0;
    bus.delta_frame  = IW'($urandom);
  endtask

  // stop_line >= 0 abandons the frame at the start of that line
  task automatic send_frame(input int min_px, input int blank_pct, input int stop_line, input int gap);
    int last_cyc;
    last_cyc = 0;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      idle();
    end
    @(negedge clk);
    bus.frame_start  = 1'b1;
    bus.is_not_blank = 1'b0;
    for (int y = 0; y < V; y++) begin
      if (y == stop_line) begin
        @(negedge clk);
        idle();
        return;
      end
      for (int x = 0; x < H; x++) begin
        @(negedge clk);
        bus.frame_start = 1'b0;
        while (int'($urandom_range(99)) < blank_pct) begin
          bus.is_not_blank = 1'b0;
          bus.delta_frame  = IW'($urandom);
          @(negedge clk);
        end
        bus.is_not_blank = 1'b1;
        bus.delta_frame  = mask[y][x] ? '1 : '0;
        if (x == 0 && y == 0) bus.min_pixels = NW'(min_px);
        last_cyc = cyc;
      end
    end
    push_expected(min_px, last_cyc + 2);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("report_seen", sb.size(), 0);
    sb.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_x_min"}, bus.x_min, 0);
    check({tag, "_x_max"}, bus.x_max, 0);
    check({tag, "_y_min"}, bus.y_min, 0);
    check({tag, "_y_max"}, bus.y_max, 0);
    check({tag, "_count"}, bus.pixel_count, 0);
    check({tag, "_found"}, bus.bbox_found, 0);
    check({tag, "_valid"}, bus.bbox_valid, 0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!areset && bus.bbox_valid) begin
        if (sb.size() == 0) begin
          check("spurious_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          check("x_min", bus.x_min, e.xmin);
          check("x_max", bus.x_max, e.xmax);
          check("y_min", bus.y_min, e.ymin);
          check("y_max", bus.y_max, e.ymax);
          check("pixel_count", bus.pixel_count, e.cnt);
          check("bbox_found", bus.bbox_found, e.found);
          check("valid_cycle", cyc, e.cyc);
          last_e = e;
        end
      end
    end
  end

  initial begin
    areset = 1'b1;
    bus.frame_start  = 1'b0;
    bus.is_not_blank = 1'b0;
    bus.delta_frame  = '0;
    bus.min_pixels   = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    areset = 1'b0;

    clear_mask();
    send_frame(1, 0, -1, 2);
    wait_drain();

    clear_mask();
    mask[50][100] = 1'b1;
    send_frame(1, 0, -1, 2);
    wait_drain();

    // second block frame starts during the first one's REPORT cycle
    clear_mask();
    for (int y = 40; y < 50; y++)
      for (int x = 10; x < 20; x++) mask[y][x] = 1'b1;
    send_frame(100, 0, -1, 2);
    send_frame(101, 0, -1, 0);
    wait_drain();

    clear_mask();
    mask[0][0]         = 1'b1;
    mask[V-1][H-1]     = 1'b1;
    send_frame(1, 5, -1, 3);
    wait_drain();

    clear_mask();
    mask[10][60] = 1'b1;
    send_frame(1, 0, 20, 2);
    clear_mask();
    mask[5][5] = 1'b1;
    send_frame(1, 0, -1, 0);
    wait_drain();

    repeat (6) @(negedge clk);
    check("hold_x_min", bus.x_min, last_e.xmin);
    check("hold_y_max", bus.y_max, last_e.ymax);
    check("hold_count", bus.pixel_count, last_e.cnt);
    check("hold_valid", bus.bbox_valid, 0);

    clear_mask();
    mask[3][40] = 1'b1;
    send_frame(1, 0, 10, 2);
    areset = 1'b1;
    #1;
    check_zero("async_reset");
    repeat (3) @(negedge clk);
    check_zero("held_reset");
    areset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bus.is_not_blank = 1'($urandom);
      bus.delta_frame  = IW'($urandom);
    end

    clear_mask();
    mask[7][3]   = 1'b1;
    mask[20][90] = 1'b1;
    mask[55][0]  = 1'b1;
    send_frame(0, 30, -1, 1);
    wait_drain();

    repeat (5) @(negedge clk);
    check("queue_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
